// File: rtl/local_store_unit_pkg.sv
// Shared definitions for the SPU local store: unit ID, quadword geometry,
// FSM state type and the response record carried through the read pipeline.
package spu_ls_pkg;

  localparam logic [2:0]  LS_UNIT_ID = 3'd7;
  localparam int unsigned QW_BYTES   = 16;

  typedef enum logic {
    LS_INIT = 1'b0,
    LS_RUN  = 1'b1
  } ls_state_t;

  // Response payload for a quadword-wide store.
  typedef struct packed {
    logic                    we;
    logic                    err;
    logic [QW_BYTES*8-1:0]   data;
  } ls_rsp_t;

endpackage

// File: rtl/local_store_unit_rsp_pipe.sv
// Fixed-latency response pipeline: RD_LAT stages of valid plus payload.
// An asynchronous flush drops everything in flight. Payload is zeroed whenever
// its valid bit is low, so the outputs read 0 between responses.
module ls_rsp_pipe
  import spu_ls_pkg::*;
#(
  parameter int unsigned RD_LAT = 2,
  parameter type         rsp_t  = ls_rsp_t
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  input  rsp_t in_rsp,
  output logic out_valid,
  output rsp_t out_rsp
);

  logic [RD_LAT-1:0] vld_q, vld_d;
  rsp_t              pay_q [RD_LAT];
  rsp_t              pay_d [RD_LAT];

  // Shift every stage one step toward the output.
  always_comb begin
    vld_d    = vld_q;
    pay_d    = pay_q;
    vld_d[0] = in_valid;
    pay_d[0] = in_valid ? in_rsp : '0;
    for (int unsigned i = 1; i < RD_LAT; i++) begin
      vld_d[i] = vld_q[i-1];
      pay_d[i] = pay_q[i-1];
    end
  end

  // Stage registers; reset discards all in-flight responses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int unsigned i = 0; i < RD_LAT; i++) begin
        pay_q[i] <= '0;
      end
    end else begin
      vld_q <= vld_d;
      for (int unsigned i = 0; i < RD_LAT; i++) begin
        pay_q[i] <= pay_d[i];
      end
    end
  end

  assign out_valid = vld_q[RD_LAT-1];
  assign out_rsp   = pay_q[RD_LAT-1];

endmodule

// File: rtl/local_store_unit.sv
// Clocked SPU local store: quadword array with byte-enable stores, range
// checking and a post-reset zeroing sweep. Requests arrive on a valid/ready
// port tagged with a unit ID; each accepted request yields one in-order
// response RD_LAT cycles after acceptance.
module local_store_unit
  import spu_ls_pkg::*;
#(
  parameter int unsigned DATA_W  = 128,
  parameter int unsigned DEPTH   = 2048,
  parameter int unsigned ADDR_W  = 32,
  parameter logic [2:0]  UNIT_ID = LS_UNIT_ID,
  parameter int unsigned RD_LAT  = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [2:0]          req_unit_id,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                rsp_valid,
  output logic                rsp_we,
  output logic [DATA_W-1:0]   rsp_data,
  output logic                rsp_err
);

  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned OFF_W = $clog2(BE_W);
  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned IW    = ADDR_W - OFF_W;

  typedef struct packed {
    logic              we;
    logic              err;
    logic [DATA_W-1:0] data;
  } rsp_t;

  ls_state_t         state_q, state_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [IW-1:0]     idx_full;
  logic [IDX_W-1:0]  idx;
  logic              in_range;
  logic              accept;
  logic              addr_off_unused;

  logic              mem_we;
  logic [IDX_W-1:0]  mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [BE_W-1:0]   mem_wbe;

  logic              pipe_in_valid;
  rsp_t              pipe_in_rsp;
  logic              pipe_out_valid;
  rsp_t              pipe_out_rsp;

  // Quadword index from the byte address; offset bits inside the word are ignored.
  assign idx_full        = req_addr[ADDR_W-1:OFF_W];
  assign idx             = idx_full[IDX_W-1:0];
  assign addr_off_unused = ^req_addr[OFF_W-1:0];

  // Range check and request acceptance.
  always_comb begin
    in_range  = ({1'b0, idx_full} < (IW+1)'(DEPTH));
    req_ready = (state_q == LS_RUN);
    accept    = req_valid && req_ready && (req_unit_id == UNIT_ID);
  end

  // INIT sweeps every word once, then the store stays in RUN until reset.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == LS_INIT) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == IDX_W'(DEPTH - 1)) begin
        state_d = LS_RUN;
      end
    end
  end

  // FSM and sweep counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= LS_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Single write port shared by the zeroing sweep and in-range stores.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = idx;
    mem_wdata = req_wdata;
    mem_wbe   = req_be;
    if (state_q == LS_INIT) begin
      mem_we    = 1'b1;
      mem_waddr = cnt_q;
      mem_wdata = '0;
      mem_wbe   = '1;
    end else if (accept && req_we && in_range) begin
      mem_we = 1'b1;
    end
  end

  // Storage array, no reset; byte lanes without an enable keep their contents.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int unsigned i = 0; i < BE_W; i++) begin
        if (mem_wbe[i]) begin
          mem_q[mem_waddr][i*8 +: 8] <= mem_wdata[i*8 +: 8];
        end
      end
    end
  end

  // First-stage response: load data is read from the array at the accept edge.
  always_comb begin
    pipe_in_valid    = accept;
    pipe_in_rsp      = '0;
    pipe_in_rsp.we   = req_we;
    pipe_in_rsp.err  = ~in_range;
    if (!req_we && in_range) begin
      pipe_in_rsp.data = mem_q[idx];
    end
  end

  ls_rsp_pipe #(
    .RD_LAT (RD_LAT),
    .rsp_t  (rsp_t)
  ) u_rsp_pipe (
    .clk       (clk),
    .rst_n     (reset_n),
    .in_valid  (pipe_in_valid),
    .in_rsp    (pipe_in_rsp),
    .out_valid (pipe_out_valid),
    .out_rsp   (pipe_out_rsp)
  );

  assign rsp_valid = pipe_out_valid;
  assign rsp_we    = pipe_out_rsp.we;
  assign rsp_err   = pipe_out_rsp.err;
  assign rsp_data  = pipe_out_rsp.data;

endmodule

// File: tb/tb_local_store_unit.sv
// Scoreboard bench for local_store_unit: the driver pushes expected responses
// from a plain array model of the store; a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_local_store_unit;
  import spu_ls_pkg::*;

  localparam int unsigned DATA_W = 128;
  localparam int unsigned DEPTH  = 2048;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned RD_LAT = 2;
  localparam int unsigned BE_W   = DATA_W / 8;

  logic              clk;
  logic              reset_n;
  logic              req_valid;
  logic              req_ready;
  logic [2:0]        req_unit_id;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [BE_W-1:0]   req_be;
  logic              rsp_valid;
  logic              rsp_we;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;

  typedef struct {
    logic              we;
    logic              err;
    logic [DATA_W-1:0] data;
    longint unsigned   due;
  } exp_t;

  exp_t              sb[$];
  exp_t              mon_e;
  logic [DATA_W-1:0] ref_mem [DEPTH];
  bit                model_ready;
  int                checks;
  int                errors;

  local_store_unit #(
    .DATA_W  (DATA_W),
    .DEPTH   (DEPTH),
    .ADDR_W  (ADDR_W),
    .UNIT_ID (LS_UNIT_ID),
    .RD_LAT  (RD_LAT)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_unit_id (req_unit_id),
    .req_we      (req_we),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_be      (req_be),
    .rsp_valid   (rsp_valid),
    .rsp_we      (rsp_we),
    .rsp_data    (rsp_data),
    .rsp_err     (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference behaviour of one accepted request.
  task automatic model_accept(input logic we, input logic [ADDR_W-1:0] addr,
                              input logic [DATA_W-1:0] wd, input logic [BE_W-1:0] be);
    exp_t            e;
    longint unsigned widx;
    widx   = longint'(addr) / BE_W;
    e.we   = we;
    e.err  = (widx >= DEPTH);
    e.data = '0;
    e.due  = $time + (RD_LAT - 1) * 10 + 5;
    if (!e.err) begin
      if (we) begin
        for (int b = 0; b < int'(BE_W); b++)
          if (be[b]) ref_mem[widx][b*8 +: 8] = wd[b*8 +: 8];
      end else begin
        e.data = ref_mem[widx];
      end
    end
    sb.push_back(e);
  endtask

  task automatic issue(input logic we, input logic [2:0] id, input logic [ADDR_W-1:0] addr,
                       input logic [DATA_W-1:0] wd, input logic [BE_W-1:0] be);
    @(negedge clk);
    req_valid   = 1'b1;
    req_we      = we;
    req_unit_id = id;
    req_addr    = addr;
    req_wdata   = wd;
    req_be      = be;
    @(posedge clk);
    if (model_ready && id == LS_UNIT_ID) model_accept(we, addr, wd, be);
  endtask

  task automatic idle();
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check("drain_empty", DATA_W'(sb.size()), '0);
  endtask

  // Measure how long ready stays low after release; memory is zero afterwards.
  task automatic wait_init();
    int n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (req_ready !== 1'b1 && n < 3000);
    check("init_cycles", DATA_W'(n), DATA_W'(DEPTH));
    for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = '0;
    model_ready = 1'b1;
  endtask

  // Monitor: every response pulse must match the oldest expectation, on time.
  always @(negedge clk) begin
    if (rsp_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got rsp_valid=1 at %0t expected no response", $time);
      end else begin
        mon_e = sb.pop_front();
        check("rsp_we",   DATA_W'(rsp_we),  DATA_W'(mon_e.we));
        check("rsp_err",  DATA_W'(rsp_err), DATA_W'(mon_e.err));
        check("rsp_data", rsp_data,         mon_e.data);
        check("rsp_time", DATA_W'($time),   DATA_W'(mon_e.due));
      end
    end
  end

  initial begin
    #2ms;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

  initial begin
    logic [ADDR_W-1:0] a;
    int unsigned       r;
    checks      = 0;
    errors      = 0;
    model_ready = 1'b0;
    reset_n     = 1'b0;
    req_valid   = 1'b0;
    req_unit_id = LS_UNIT_ID;
    req_we      = 1'b0;
    req_addr    = '0;
    req_wdata   = '0;
    req_be      = '0;
    repeat (3) @(negedge clk);
    check("rst_ready",    DATA_W'(req_ready), '0);
    check("rst_rsp_valid", DATA_W'(rsp_valid), '0);
    check("rst_rsp_we",   DATA_W'(rsp_we), '0);
    check("rst_rsp_err",  DATA_W'(rsp_err), '0);
    check("rst_rsp_data", rsp_data, '0);

    // Hold a load of address 0 through INIT.
    req_valid = 1'b1;
    reset_n   = 1'b1;
    wait_init();
    issue(1'b0, LS_UNIT_ID, 32'h0, '0, '0);

    // Full store then load of the same quadword via a different offset.
    issue(1'b1, LS_UNIT_ID, 32'h10, 128'd120, 16'hFFFF);
    issue(1'b0, LS_UNIT_ID, 32'h1F, '0, '0);

    // Partial store clearing the low four bytes.
    issue(1'b1, LS_UNIT_ID, 32'h20, '1, 16'hFFFF);
    issue(1'b1, LS_UNIT_ID, 32'h20, '0, 16'h000F);
    issue(1'b0, LS_UNIT_ID, 32'h20, '0, '0);
    issue(1'b1, LS_UNIT_ID, 32'h20, '1, 16'h0000);

    // Out of range and unit mismatch.
    issue(1'b1, LS_UNIT_ID, 32'h8000, '1, 16'hFFFF);
    issue(1'b0, LS_UNIT_ID, 32'hFFFF_FFF0, '0, '0);
    issue(1'b1, 3'd3, 32'h30, 128'hDEAD, 16'hFFFF);
    issue(1'b0, 3'd3, 32'h0, '0, '0);
    issue(1'b0, LS_UNIT_ID, 32'h30, '0, '0);
    issue(1'b0, LS_UNIT_ID, 32'h7FF0, '0, '0);

    // Back-to-back streaming.
    for (int k = 0; k < 16; k++)
      issue(1'b1, LS_UNIT_ID, 32'(k * 16), DATA_W'(120 + 10 * k), 16'hFFFF);
    for (int k = 0; k < 16; k++)
      issue(1'b0, LS_UNIT_ID, 32'(k * 16), '0, '0);
    idle();
    drain();

    // Randomised traffic over a small hot region plus occasional outliers.
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 99);
      if (r < 70)      a = 32'($urandom_range(0, 63) * 16 + $urandom_range(0, 15));
      else if (r < 85) a = 32'($urandom_range(DEPTH * 16, 32'hFFFF_FFFF));
      else             a = 32'($urandom_range(0, DEPTH * 16 - 1));
      if ($urandom_range(0, 99) < 15) begin
        idle();
      end else begin
        issue(1'($urandom_range(0, 1)),
              ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 6)) : LS_UNIT_ID,
              a, {$urandom, $urandom, $urandom, $urandom}, 16'($urandom));
      end
    end
    idle();
    drain();

    // Reset while two loads are in flight: neither may appear.
    issue(1'b0, LS_UNIT_ID, 32'h10, '0, '0);
    issue(1'b0, LS_UNIT_ID, 32'h20, '0, '0);
    #1;
    reset_n     = 1'b0;
    model_ready = 1'b0;
    sb.delete();
    req_valid   = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("rst_flight_valid", DATA_W'(rsp_valid), '0);
    end
    reset_n = 1'b1;
    wait_init();
    for (int k = 0; k < 8; k++)
      issue(1'b0, LS_UNIT_ID, 32'(k * 16), '0, '0);
    issue(1'b0, LS_UNIT_ID, 32'h20, '0, '0);
    idle();
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/local_store_unit.md
Name: local_store_unit

Overview:
Parametrised, clocked SPU local store that replaces the combinational quadword data memory.
- Serves load/store requests tagged with the load/store unit ID through a valid/ready request port.
- Returns one response per accepted request after a fixed, parametrised read latency.
- Adds byte-enable stores, out-of-range error reporting and a post-reset memory-clear sweep.
- Sits after the execute stage. The pipeline drives the request from the computed address and the RC register value, and the response feeds register writeback.

Parameters:
DATA_W, 128, word width in bits; multiple of 8, power of two.
DEPTH, 2048, number of DATA_W words; power of two.
ADDR_W, 32, byte-address width.
UNIT_ID, 3'd7, unit ID this store answers to.
RD_LAT, 2, request-accept to response latency in cycles; legal 1..4.

Ports:
clk  in  1  clock; all state updates on the rising edge.
reset_n  in  1  asynchronous, active-low reset.
req_valid  in  1  request present.
req_ready  out  1  store can accept a request this cycle.
req_unit_id  in  3  unit ID of the issuing instruction.
req_we  in  1  1 = store, 0 = load.
req_addr  in  ADDR_W  byte address.
req_wdata  in  DATA_W  store data.
req_be  in  DATA_W/8  store byte enables; bit i covers byte lane i.
rsp_valid  out  1  response valid; single-cycle pulse per response.
rsp_we  out  1  echoes req_we of the request being answered.
rsp_data  out  DATA_W  load data; 0 for stores and for errored requests.
rsp_err  out  1  request address was out of range.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - req_ready=0, rsp_valid=0, rsp_we=0, rsp_data=0, rsp_err=0.
  - Response pipeline flushed; FSM goes to INIT; init counter=0.
- FSM states: INIT and RUN.
  - INIT: writes 0 to word[cnt] each cycle and increments cnt. req_ready=0. At cnt==DEPTH-1 the FSM goes to RUN on the next edge (DEPTH cycles total), and cnt wraps to 0.
  - RUN: req_ready=1 permanently; there is no response backpressure.
- Accept: req_valid & req_ready & (req_unit_id==UNIT_ID). Mismatched unit IDs are silently dropped: no memory effect, no response.
- Index: idx = req_addr >> log2(DATA_W/8). The low offset bits are ignored (quadword-aligned access).
- Range check: idx >= DEPTH means out of range. The request is still accepted, no memory access is made, and the response has rsp_err=1 and rsp_data=0.
- Store: on the accept edge, byte lane i of word[idx] takes req_wdata lane i when req_be[i]=1; other lanes are unchanged. be==0 is a legal no-op store and still gets a response.
- Load: word[idx] is read at the accept edge.
- Latency: a request accepted at edge t produces rsp_valid high during cycle t+RD_LAT. Throughput is one request per cycle, and responses return in order.
- Ordering: a store accepted at edge t is visible to a load accepted at edge t+1. Store and load cannot be accepted in the same cycle (single request port).
- Reset mid-operation (in INIT or with responses in flight): in-flight responses are discarded, never emitted; the INIT sweep restarts from 0.
- Memory array has no reset; it is zeroed only by the INIT sweep.

Decomposition:
- Package spu_ls_pkg holds:
  - LS_UNIT_ID = 3'd7
  - QW_BYTES = 16
  - the ls_state_t enum {LS_INIT, LS_RUN}
  - a response struct {we, err, data}
- Sub-module ls_rsp_pipe: RD_LAT-deep valid/payload shift register with async active-low flush. It takes the first-stage response and emits rsp_*.
- The top level holds the FSM, init counter, array, byte-enable merge and range check.

Test Plan:
- INIT timing: release reset, then hold req_valid=1 with a load of addr 0x0 -> req_ready=0 for exactly 2048 cycles, then 1. The first accepted load returns rsp_data=0, rsp_err=0 two cycles later.
- Full store then load: store addr 0x10, wdata 128'd120, be=16'hFFFF, then load addr 0x1F next cycle -> load response rsp_data=128'd120, rsp_we=0. The store response arrives first with rsp_we=1, rsp_data=0.
- Partial store: word at 0x20 holds all-FF; store 0x20 with wdata 0, be=16'h000F, then load 0x20 -> rsp_data=128'hFFFF...FFFF_0000_0000 (low 4 bytes cleared).
- Out of range / unit mismatch: store to addr 0x8000 (idx 2048) -> rsp_err=1, rsp_data=0. Load 0x0 with req_unit_id=3 -> no rsp_valid, and memory is unchanged.
- Back-to-back streaming: 16 consecutive stores to addresses 0x0, 0x10, … with data 120+10k, then 16 loads -> 32 responses, one per cycle, in order, each load returning 120+10k.
- Reset mid-flight: assert reset_n=0 while 2 loads are in the pipe -> no rsp_valid pulses for them. After release, INIT runs again and memory reads 0.
